// File: rtl/led_pattern_ctrl_if.sv
// Button, LED and status signals between the board and the LED pattern controller.
interface led_pattern_ctrl_if;
    logic [1:0] btn_i;    // raw buttons: [0] mode-next, [1] speed-next
    logic [3:0] led_o;    // LED drive, 1 = lit
    logic [1:0] mode_o;   // 0=OFF 1=SWEEP 2=COUNT 3=BLINK
    logic [1:0] speed_o;  // speed index 0..3

    modport master (output btn_i, input led_o, mode_o, speed_o);
    modport slave  (input btn_i, output led_o, mode_o, speed_o);
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: button sync/debounce, mode FSM, variable-rate
// prescaler and step sequencer driving the 4-LED display.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_OFF   | LEDs dark, step held at 0
// ST_SWEEP | single lit LED bouncing across, 6 steps
// ST_COUNT | LEDs show a 4-bit binary count, 16 steps
// ST_BLINK | all LEDs toggle on/off, 2 steps
module led_pattern_ctrl #(
    parameter int DIV_W = 23,
    parameter int DB_W  = 20
) (
    input logic              clk,
    input logic              rst,
    led_pattern_ctrl_if.slave bus
);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_BLINK = 2'd3;

    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       db_level;
    logic [1:0]       level_dly_q;
    logic [1:0]       press_q;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] tick_mask;
    logic [3:0]       step_q, step_d;
    logic [3:0]       step_last;
    logic [3:0]       led_q, led_d;
    logic             tick;
    logic             mode_press;
    logic             speed_press;

    // Two-flop synchronizer for both raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_db
        logic [DB_W-1:0] cnt_q;
        logic            lvl_q;

        // Level follows the sample only after 2^DB_W consecutive differing samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[g] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == {DB_W{1'b1}}) begin
                lvl_q <= sync2_q[g];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign db_level[g] = lvl_q;
    end

    // One-cycle press pulse on a rising debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_dly_q <= '0;
            press_q     <= '0;
        end else begin
            level_dly_q <= db_level;
            press_q     <= db_level & ~level_dly_q;
        end
    end

    assign mode_press  = press_q[0];
    assign speed_press = press_q[1];

    // Faster speeds look at fewer low prescaler bits, halving the step period each time.
    assign tick_mask = {DIV_W{1'b1}} >> speed_q;
    assign tick      = &(presc_q | ~tick_mask);

    // Next-state for mode, speed, prescaler, step and LED decode.
    always_comb begin
        mode_d    = mode_q;
        speed_d   = speed_q;
        presc_d   = presc_q + 1'b1;
        step_d    = step_q;
        step_last = 4'd0;
        led_d     = 4'b0000;

        case (mode_q)
            ST_SWEEP: step_last = 4'd5;
            ST_COUNT: step_last = 4'd15;
            ST_BLINK: step_last = 4'd1;
            default:  step_last = 4'd0;
        endcase

        if (speed_press) begin
            speed_d = speed_q + 2'd1;
        end

        // A mode press beats a coincident tick: step and prescaler restart.
        if (mode_press) begin
            case (mode_q)
                ST_OFF:   mode_d = ST_SWEEP;
                ST_SWEEP: mode_d = ST_COUNT;
                ST_COUNT: mode_d = ST_BLINK;
                default:  mode_d = ST_OFF;
            endcase
            presc_d = '0;
            step_d  = 4'd0;
        end else if (tick) begin
            if (mode_q == ST_OFF || step_q >= step_last) begin
                step_d = 4'd0;
            end else begin
                step_d = step_q + 4'd1;
            end
        end

        case (mode_q)
            ST_SWEEP: begin
                case (step_q)
                    4'd0:    led_d = 4'b0001;
                    4'd1:    led_d = 4'b0010;
                    4'd2:    led_d = 4'b0100;
                    4'd3:    led_d = 4'b1000;
                    4'd4:    led_d = 4'b0100;
                    4'd5:    led_d = 4'b0010;
                    default: led_d = 4'b0000;
                endcase
            end
            ST_COUNT: led_d = step_q;
            ST_BLINK: led_d = (step_q == 4'd1) ? 4'b1111 : 4'b0000;
            default:  led_d = 4'b0000;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= ST_OFF;
            speed_q <= 2'd0;
            presc_q <= '0;
            step_q  <= 4'd0;
            led_q   <= 4'b0000;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            led_q   <= led_d;
        end
    end

    assign bus.led_o   = led_q;
    assign bus.mode_o  = mode_q;
    assign bus.speed_o = speed_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with a cycle-level behavioural model.
module tb_led_pattern_ctrl;

    localparam int DIV_W = 5;
    localparam int DB_W  = 2;

    logic clk = 1'b0;
    logic rst;

    led_pattern_ctrl_if bus ();

    led_pattern_ctrl #(.DIV_W(DIV_W), .DB_W(DB_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model state
    logic [1:0] m_s1, m_s2, m_lvl, m_rise, m_pulse;
    int         m_run [2];
    int         m_mode, m_speed, m_presc, m_step;
    logic [3:0] m_led;
    int         n_coinc;
    bit         wrap_seen;

    int         seq_len [4]   = '{1, 6, 16, 2};
    logic [3:0] sweep_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_pulse = '0;
        m_run[0] = 0; m_run[1] = 0;
        m_mode = 0; m_speed = 0; m_presc = 0; m_step = 0;
        m_led = '0;
    endtask

    // One clock edge of the reference behaviour, evaluated from pre-edge values.
    task automatic model_step(input logic [1:0] b);
        int         period;
        bit         tick;
        logic [3:0] led_new;
        logic       sample;
        case (m_mode)
            1:       led_new = (m_step < 6) ? sweep_tab[m_step] : 4'b0000;
            2:       led_new = 4'(m_step);
            3:       led_new = (m_step == 1) ? 4'hF : 4'h0;
            default: led_new = 4'h0;
        endcase
        period = 1 << (DIV_W - m_speed);
        tick   = (m_presc % period) == (period - 1);
        if (m_pulse[0]) begin
            if (tick && m_mode != 0) n_coinc++;
            m_mode  = (m_mode + 1) % 4;
            m_step  = 0;
            m_presc = 0;
        end else begin
            m_presc = (m_presc + 1) % (1 << DIV_W);
            if (tick) m_step = (m_step + 1) % seq_len[m_mode];
        end
        if (m_pulse[1]) m_speed = (m_speed + 1) % 4;
        m_led   = led_new;
        m_pulse = m_rise;
        for (int i = 0; i < 2; i++) begin
            sample    = m_s2[i];
            m_rise[i] = 1'b0;
            if (sample != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == (1 << DB_W)) begin
                    m_lvl[i]  = sample;
                    m_run[i]  = 0;
                    m_rise[i] = sample;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic cyc(input logic [1:0] b);
        @(negedge clk);
        bus.btn_i = b;
        @(posedge clk);
        model_step(b);
        #1;
        chk("led", bus.led_o, m_led);
        chk("mode", bus.mode_o, m_mode);
        chk("speed", bus.speed_o, m_speed);
    endtask

    task automatic press(input logic [1:0] b);
        repeat (6) cyc(b);
        repeat (8) cyc(2'b00);
    endtask

    task automatic run_measure(input int n, input int per, input string tag);
        logic [3:0] prev  = bus.led_o;
        int         since = 0;
        bit         armed = 0;
        for (int i = 0; i < n; i++) begin
            cyc(2'b00);
            since++;
            if (bus.led_o !== prev) begin
                if (armed) chk(tag, since, per);
                if (prev == 4'hF && bus.led_o == 4'h0) wrap_seen = 1;
                armed = 1;
                since = 0;
                prev  = bus.led_o;
            end
        end
    endtask

    initial begin
        int mb, sb, budget;
        n_coinc   = 0;
        wrap_seen = 0;
        bus.btn_i = 2'b00;
        rst       = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", bus.led_o, 0);
        chk("rst_mode", bus.mode_o, 0);
        chk("rst_speed", bus.speed_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Glitch of 3 clocks, then a held press
        repeat (3) cyc(2'b01);
        repeat (4) cyc(2'b00);
        for (int k = 1; k <= 10; k++) begin
            cyc(2'b01);
            chk("hold_mode", bus.mode_o, (k >= 8) ? 1 : 0);
        end
        repeat (8) cyc(2'b00);
        chk("single_press", bus.mode_o, 1);

        // SWEEP at speed 0
        run_measure(32 * 8, 32, "sweep_period");

        // COUNT and speed wrap
        press(2'b01);
        for (int i = 0; i < 3; i++) begin
            press(2'b10);
            chk("speed_step", bus.speed_o, i + 1);
        end
        run_measure(40, 4, "count_period_s3");
        press(2'b10);
        chk("speed_wrap", bus.speed_o, 0);
        wrap_seen = 0;
        run_measure(32 * 18, 32, "count_period_s0");
        chk("count_wrap_seen", wrap_seen, 1);

        // BLINK then back to OFF
        press(2'b01);
        chk("blink_mode", bus.mode_o, 3);
        run_measure(32 * 5, 32, "blink_period");
        press(2'b01);
        for (int i = 0; i < 64; i++) begin
            cyc(2'b00);
            chk("off_led", bus.led_o, 0);
        end

        // Mode presses landing on ticks at speed 3
        for (int i = 0; i < 3; i++) press(2'b10);
        press(2'b01);
        for (int off = 0; off < 4; off++) begin
            repeat (off) cyc(2'b00);
            press(2'b01);
        end
        chk("coinc_seen", n_coinc > 0, 1);

        // Both buttons in the same cycle
        mb = m_mode;
        sb = m_speed;
        press(2'b11);
        chk("both_mode", bus.mode_o, (mb + 1) % 4);
        chk("both_speed", bus.speed_o, (sb + 1) % 4);

        // Randomized stimulus
        for (int n = 0; n < 300; n++) begin
            logic [1:0] b;
            int         len;
            b   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 10);
            repeat (len) cyc(b);
        end

        // Reach COUNT with LED=9, then reset mid-cycle
        budget = 0;
        while (m_mode != 2 && budget < 8) begin
            press(2'b01);
            budget++;
        end
        if (m_speed == 0) press(2'b10);
        budget = 0;
        while (!(m_mode == 2 && m_led == 4'd9) && budget < 4000) begin
            cyc(2'b00);
            budget++;
        end
        chk("reach_step9", (m_mode == 2 && m_led == 4'd9), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", bus.led_o, 0);
        chk("async_rst_mode", bus.mode_o, 0);
        chk("async_rst_speed", bus.speed_o, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_led", bus.led_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) cyc(2'b00);
        press(2'b01);
        repeat (40) cyc(2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
